// File: rtl/dffram_256x16.sv
// -----------------------------------------------------------------------------
// dffram_256x16
//   Single-port synchronous scratch RAM built from flip-flops: 256 words of
//   16 bits, per-byte write enables, and a registered read port with one
//   cycle of latency.
//
// Ports
//   CLK   in   1       clock; all state changes on the rising edge
//   RST   in   1       synchronous active-high reset; clears Do0 only
//   EN0   in   1       port enable; no read or write while low
//   A0    in   ADDR_W  word address
//   Di0   in   DATA_W  write data
//   Do0   out  DATA_W  registered read data
//   WE0   in   DATA_W/8 byte write enables (WE0[b] covers Di0[8b+7:8b])
//
// Build option
//   DFFRAM_WRITE_THROUGH_EN  defined   : write-first; an enabled write cycle
//                                        returns the merged (new) word on Do0.
//                            undefined : read-before-write; an enabled write
//                                        cycle returns the previously stored
//                                        word on Do0.
// -----------------------------------------------------------------------------
module dffram_256x16 #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN0,
   input  logic [ADDR_W-1:0]     A0,
   input  logic [DATA_W-1:0]     Di0,
   output logic [DATA_W-1:0]     Do0,
   input  logic [DATA_W/8-1:0]   WE0
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] do_q;
   logic [DATA_W-1:0] do_d;

   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] merged_word;
   logic              wr_en;

   // The stored word at A0 with the enabled byte lanes replaced by Di0.
   // Writing the whole merged word back is equivalent to per-lane writes
   // because untouched lanes are rewritten with their own value.
   always_comb begin
      // NOTE: combinational blocks use blocking assignments and give every
      // output a default first, so no latch is inferred.
      rd_word     = mem_q[A0];
      merged_word = rd_word;
      for (int b = 0; b < LANES; b++) begin
         if (WE0[b]) begin
            merged_word[8*b +: 8] = Di0[8*b +: 8];
         end
      end

      // Reset blocks writes even when the port is enabled.
      wr_en = !RST && EN0 && (|WE0);

      do_d = do_q;
      if (RST) begin
         do_d = '0;
      end else if (EN0) begin
`ifdef DFFRAM_WRITE_THROUGH_EN
         do_d = merged_word;
`else
         do_d = rd_word;
`endif
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // flops sample their inputs from the same edge.
   always_ff @(posedge CLK) begin
      do_q <= do_d;
   end

   // NOTE: the array has no reset on purpose; its contents survive RST and
   // are undefined after power-up, which keeps the flops free of reset logic.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[A0] <= merged_word;
      end
   end

   // Output comes straight from the register: no path from A0/Di0 to Do0.
   assign Do0 = do_q;

endmodule

// File: tb/tb_dffram_256x16.sv
// -----------------------------------------------------------------------------
// tb_dffram_256x16
//   Self-checking bench for dffram_256x16. A byte-level reference model of the
//   memory predicts Do0 after every edge; a table of hand-computed vectors
//   covers the byte-lane, enable, collision and reset corner cases, followed
//   by a full address sweep and a randomized run.
//   Define DFFRAM_WRITE_THROUGH_EN for both bench and RTL to test write-first.
// -----------------------------------------------------------------------------
module tb_dffram_256x16;

   logic        CLK;
   logic        RST;
   logic        EN0;
   logic [7:0]  A0;
   logic [15:0] Di0;
   logic [15:0] Do0;
   logic [1:0]  WE0;

   int checks = 0;
   int errors = 0;

`ifdef DFFRAM_WRITE_THROUGH_EN
   localparam bit WRITE_FIRST = 1'b1;
`else
   localparam bit WRITE_FIRST = 1'b0;
`endif

   dffram_256x16 dut (
      .CLK (CLK),
      .RST (RST),
      .EN0 (EN0),
      .A0  (A0),
      .Di0 (Di0),
      .Do0 (Do0),
      .WE0 (WE0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: bytes of each word plus a "known" flag per byte, since
   // the array is undefined until written.
   logic [7:0] m_byte  [256][2];
   bit         m_known [256][2];
   logic [15:0] m_do;
   bit          m_do_known;

   typedef struct {
      bit          rst;
      bit          en;
      logic [7:0]  a;
      logic [15:0] di;
      logic [1:0]  we;
      logic [15:0] exp_rbw;   // expected Do0, read-before-write build
      logic [15:0] exp_wf;    // expected Do0, write-first build
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [15:0] actual,
                        input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: Do0=%h expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle, advance the model by the spec rules, compare Do0.
   task automatic op(input bit rst, input bit en, input logic [7:0] a,
                     input logic [15:0] di, input logic [1:0] we,
                     input string name);
      logic [15:0] old_w;
      logic [15:0] new_w;
      bit          old_k;
      bit          new_k;
      RST = rst; EN0 = en; A0 = a; Di0 = di; WE0 = we;
      if (rst) begin
         m_do       = 16'h0000;
         m_do_known = 1'b1;
      end else if (en) begin
         old_w = {m_byte[a][1], m_byte[a][0]};
         old_k = m_known[a][0] && m_known[a][1];
         new_w = old_w;
         new_k = 1'b1;
         for (int b = 0; b < 2; b++) begin
            if (we[b]) begin
               m_byte[a][b]  = di[8*b +: 8];
               m_known[a][b] = 1'b1;
            end else if (!m_known[a][b]) begin
               new_k = 1'b0;
            end
         end
         new_w = {m_byte[a][1], m_byte[a][0]};
         if (WRITE_FIRST) begin
            m_do       = new_w;
            m_do_known = new_k;
         end else begin
            m_do       = old_w;
            m_do_known = old_k;
         end
      end
      @(posedge CLK);
      #1;
      if (m_do_known) check(name, Do0, m_do);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         for (int b = 0; b < 2; b++) begin
            m_byte[i][b]  = 8'h00;
            m_known[i][b] = 1'b0;
         end
      end
      m_do       = 16'h0000;
      m_do_known = 1'b0;

      //         rst   en    a      di        we     rbw       wf
      vecs[0]  = '{1'b0, 1'b1, 8'h10, 16'hAAAA, 2'b11, 16'h0010, 16'hAAAA};
      vecs[1]  = '{1'b0, 1'b1, 8'h10, 16'h1234, 2'b01, 16'hAAAA, 16'hAA34};
      vecs[2]  = '{1'b0, 1'b1, 8'h10, 16'h5600, 2'b10, 16'hAA34, 16'h5634};
      vecs[3]  = '{1'b0, 1'b1, 8'h10, 16'h0000, 2'b00, 16'h5634, 16'h5634};
      vecs[4]  = '{1'b0, 1'b0, 8'h20, 16'hFFFF, 2'b11, 16'h5634, 16'h5634};
      vecs[5]  = '{1'b0, 1'b1, 8'h20, 16'h0000, 2'b00, 16'h0020, 16'h0020};
      vecs[6]  = '{1'b0, 1'b1, 8'h05, 16'h1111, 2'b11, 16'h0005, 16'h1111};
      vecs[7]  = '{1'b0, 1'b1, 8'h05, 16'h2222, 2'b11, 16'h1111, 16'h2222};
      vecs[8]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 2'b00, 16'h2222, 16'h2222};
      vecs[9]  = '{1'b1, 1'b1, 8'h30, 16'hBEEF, 2'b11, 16'h0000, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 8'h30, 16'h0000, 2'b00, 16'h0030, 16'h0030};
      vecs[11] = '{1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000, 16'h0000};
      vecs[12] = '{1'b0, 1'b1, 8'h05, 16'h0000, 2'b00, 16'h2222, 16'h2222};

      // Reset state.
      op(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, "reset");

      // Full sweep: write i to address i, then read every address back.
      for (int i = 0; i < 256; i++) begin
         op(1'b0, 1'b1, 8'(i), 16'(i), 2'b11, "sweep_wr");
      end
      for (int i = 0; i < 256; i++) begin
         op(1'b0, 1'b1, 8'(i), 16'hDEAD, 2'b00, "sweep_rd_model");
         check("sweep_rd", Do0, 16'(i));
      end

      // Corner-case table: byte lanes, enable gating, collision, reset.
      for (int v = 0; v < 13; v++) begin
         op(vecs[v].rst, vecs[v].en, vecs[v].a, vecs[v].di, vecs[v].we,
            $sformatf("vec%0d_model", v));
         check($sformatf("vec%0d", v), Do0,
               WRITE_FIRST ? vecs[v].exp_wf : vecs[v].exp_rbw);
      end

      // Hold: several disabled cycles keep Do0 at its last value.
      op(1'b0, 1'b1, 8'h10, 16'h0000, 2'b00, "hold_setup");
      for (int k = 0; k < 3; k++) begin
         op(1'b0, 1'b0, 8'(k), 16'hFFFF, 2'b11, "hold_model");
         check("hold", Do0, 16'h5634);
      end

      // Back-to-back write then read of the same address.
      op(1'b0, 1'b1, 8'h77, 16'hC3A5, 2'b11, "b2b_wr");
      op(1'b0, 1'b1, 8'h77, 16'h0000, 2'b00, "b2b_rd_model");
      check("b2b_rd", Do0, 16'hC3A5);

      // Randomized run; addresses often confined to a small window so
      // collisions and partial-lane merges happen frequently.
      for (int n = 0; n < 3000; n++) begin
         bit          r_rst;
         bit          r_en;
         logic [7:0]  r_a;
         r_rst = ($urandom_range(0, 31) == 0);
         r_en  = ($urandom_range(0, 3) != 0);
         r_a   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                             : 8'($urandom_range(0, 255));
         op(r_rst, r_en, r_a, 16'($urandom), 2'($urandom), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
